// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline boundary register.
// The state encoding doubles as the occupancy count driven on the level port.
package pipe_pkg;

  localparam int DEFAULT_DATA_W = 64;
  localparam int DEFAULT_CTRL_W = 8;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMREG   = 3;
  localparam int CTRL_JUMP     = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid bit plus data and control bundles.
// Clearing an entry drops valid and zeroes control; the data bundle is left stale.
module pipe_slot #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] din,
  input  logic [CTRL_W-1:0] cin,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  // Clear wins over load so a kill can never leave live control bits behind.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (clear) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = din;
      ctrl_d  = cin;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Valid/ready pipeline boundary register with optional two-entry skid buffer,
// synchronous flush that kills control bits, and an occupancy output.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CTRL_W = DEFAULT_CTRL_W,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        level
);

  pipe_state_e state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        accept, issue;
  logic        head_load, head_clear, skid_load, skid_clear;
  logic        head_valid, skid_valid;
  logic [DATA_W-1:0] head_data, skid_data, head_din;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl, head_cin;

  // in_ready_q is low through reset; without a skid slot it also gates the comb path.
  assign in_ready = (SKID != 0) ? in_ready_q : (in_ready_q & (~head_valid | out_ready));
  assign accept   = in_valid & in_ready;
  assign issue    = head_valid & out_ready;

  // The skid slot is only valid in FULL, where it is the sole source for a head refill.
  assign head_din = skid_valid ? skid_data : in_data;
  assign head_cin = skid_valid ? skid_ctrl : in_ctrl;

  always_comb begin
    state_d    = state_q;
    head_load  = 1'b0;
    head_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush) begin
      state_d    = EMPTY;
      head_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = ONE;
            head_load = 1'b1;
          end
        end
        ONE: begin
          if (accept && issue) begin
            head_load = 1'b1;
          end else if (accept && (SKID != 0)) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end else if (issue) begin
            state_d    = EMPTY;
            head_clear = 1'b1;
          end
        end
        FULL: begin
          if (issue) begin
            state_d    = ONE;
            head_load  = 1'b1;
            skid_clear = 1'b1;
          end
        end
        default: begin
          state_d    = EMPTY;
          head_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_head (
    .clk   (clk),
    .reset (reset),
    .load  (head_load),
    .clear (head_clear),
    .din   (head_din),
    .cin   (head_cin),
    .valid (head_valid),
    .data  (head_data),
    .ctrl  (head_ctrl)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .clear (skid_clear),
        .din   (in_data),
        .cin   (in_ctrl),
        .valid (skid_valid),
        .data  (skid_data),
        .ctrl  (skid_ctrl)
      );
    end else begin : g_no_skid
      assign skid_valid = 1'b0;
      assign skid_data  = '0;
      assign skid_ctrl  = '0;
    end
  endgenerate

  assign out_valid = head_valid;
  assign out_data  = head_data;
  assign out_ctrl  = head_ctrl;
  assign level     = state_q;

endmodule
